// File: rtl/counter_pkg.sv
// Shared definitions for the down_timer control FSM.
package counter_pkg;

    // IDLE: armed or expired; RUN: decrementing; PAUSED: frozen.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

endpackage : counter_pkg

// File: rtl/down_timer.sv
// Loadable down-counter timer with pause/resume, optional auto-reload and a
// registered one-cycle done pulse on expiry.
//
// Command priority, highest first: reset > load > pause > start.
// There is no valid/ready handshake: every command is a level sampled on the
// rising edge of clk and acts on that edge.
module down_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output state_t           state_dbg
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    // Registers: FSM state, count, reload value and the done flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // Next-state, next-count and expiry decode.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (load) begin
            // Load wins in every state; a run in progress is abandoned silently.
            count_d  = load_val;
            reload_d = load_val;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // A zero count has nothing to time, so start is ignored.
                    if (start && (count_q != ZERO)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (count_q == ONE) begin
                        done_d = 1'b1;
                        if (auto_reload) begin
                            count_d = reload_q;
                        end else begin
                            count_d = ZERO;
                            state_d = IDLE;
                        end
                    end else if (count_q == ZERO) begin
                        // Unreachable in normal operation; never underflow.
                        state_d = IDLE;
                    end else begin
                        count_d = count_q - ONE;
                    end
                end
                PAUSED: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign count     = count_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule : down_timer

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer (WIDTH=8): directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_down_timer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    counter_pkg::state_t state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: mode 0 idle, 1 running, 2 paused.
    int m_mode   = 0;
    int m_count  = 0;
    int m_reload = 0;
    int m_done   = 0;

    down_timer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .pause       (pause),
        .auto_reload (auto_reload),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    // Clock block.
    always #5 clk = ~clk;

    // Model update from the commands present at the coming edge.
    task automatic model_step();
        if (reset) begin
            m_mode = 0; m_count = 0; m_reload = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (load) begin
                m_count = int'(load_val); m_reload = int'(load_val); m_mode = 0;
            end else if (m_mode == 1) begin
                if (pause) m_mode = 2;
                else if (m_count == 1) begin
                    m_done = 1;
                    if (auto_reload) m_count = m_reload;
                    else begin m_count = 0; m_mode = 0; end
                end else m_count = m_count - 1;
            end else if (m_mode == 0) begin
                if (start && m_count != 0) m_mode = 1;
            end else begin
                if (start) m_mode = 1;
            end
        end
    endtask

    // Driver: one clock edge, model advanced alongside, outputs settle by #1.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; load = 1'b0; load_val = '0;
        start = 1'b0; pause = 1'b0; auto_reload = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_val = WIDTH'(v);
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        load = 1'b1; load_val = 8'd33; start = 1'b1; pause = 1'b1;
        reset = 1'b1;
        tick();
        idle_inputs();
        n_cmp++; if (count !== 8'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
    endtask

    task automatic test_basic();
        do_reset();
        do_load(5);
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || count !== 8'd5) begin n_bad++; $display("FAIL basic_start busy=%b count=%0d exp busy=1 count=5", busy, count); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_cmp++;
            if (count !== WIDTH'(5 - i) || done !== (i == 5) || busy !== (i < 5)) begin
                n_bad++;
                $display("FAIL basic_cyc%0d count=%0d done=%b busy=%b exp count=%0d done=%b busy=%b",
                         i, count, done, busy, 5 - i, (i == 5), (i < 5));
            end
        end
        tick();
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || count !== 8'd0) begin n_bad++; $display("FAIL basic_after done=%b busy=%b count=%0d exp 0/0/0", done, busy, count); end
    endtask

    task automatic test_auto_reload();
        int exp_c[6] = '{2, 1, 3, 2, 1, 3};
        do_reset();
        do_load(3);
        auto_reload = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_cmp++;
            if (count !== WIDTH'(exp_c[i-1]) || done !== (i % 3 == 0) || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL auto_cyc%0d count=%0d done=%b busy=%b exp count=%0d done=%b busy=1",
                         i, count, done, busy, exp_c[i-1], (i % 3 == 0));
            end
        end
        // N==1 with auto_reload pulses done every cycle.
        do_load(1);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++; if (done !== 1'b1 || count !== 8'd1) begin n_bad++; $display("FAIL auto_n1_cyc%0d done=%b count=%0d exp done=1 count=1", i, done, count); end
        end
        auto_reload = 1'b0;
        do_load(0);
    endtask

    task automatic test_pause();
        do_reset();
        do_load(10);
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        n_cmp++; if (count !== 8'd6) begin n_bad++; $display("FAIL pause_pre count=%0d exp=6", count); end
        pause = 1'b1; start = 1'b1; tick(); start = 1'b0; pause = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            n_cmp++; if (count !== 8'd6 || busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL pause_hold%0d count=%0d busy=%b exp count=6 busy=0", i, count, busy); end
        end
        pause = 1'b1; tick(); pause = 1'b0;
        n_cmp++; if (count !== 8'd6 || busy !== 1'b0) begin n_bad++; $display("FAIL pause_in_paused count=%0d busy=%b exp 6/0", count, busy); end
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++; if (count !== 8'd6 || busy !== 1'b1) begin n_bad++; $display("FAIL pause_resume count=%0d busy=%b exp 6/1", count, busy); end
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_cmp++;
            if (count !== WIDTH'(6 - i) || done !== (i == 6)) begin
                n_bad++;
                $display("FAIL pause_run%0d count=%0d done=%b exp count=%0d done=%b", i, count, done, 6 - i, (i == 6));
            end
        end
    endtask

    task automatic test_zero_load();
        do_reset();
        do_load(0);
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (busy !== 1'b0 || count !== 8'd0 || done !== 1'b0) begin n_bad++; $display("FAIL zero_start%0d busy=%b count=%0d done=%b exp 0/0/0", i, busy, count, done); end
        end
        load = 1'b1; load_val = 8'd7; tick(); load = 1'b0; start = 1'b0;
        n_cmp++; if (busy !== 1'b0 || count !== 8'd7) begin n_bad++; $display("FAIL load_start busy=%b count=%0d exp busy=0 count=7", busy, count); end
    endtask

    task automatic test_abort();
        do_reset();
        do_load(12);
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        n_cmp++; if (count !== 8'd9) begin n_bad++; $display("FAIL abort_pre count=%0d exp=9", count); end
        reset = 1'b1; load = 1'b1; load_val = 8'd44; start = 1'b1; tick(); idle_inputs();
        n_cmp++; if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL abort_reset count=%0d busy=%b done=%b exp 0/0/0", count, busy, done); end
        do_load(30);
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        load = 1'b1; load_val = 8'd20; pause = 1'b1; start = 1'b1; tick(); idle_inputs();
        n_cmp++; if (count !== 8'd20 || busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL abort_load count=%0d busy=%b done=%b exp 20/0/0", count, busy, done); end
        tick();
        n_cmp++; if (done !== 1'b0 || count !== 8'd20) begin n_bad++; $display("FAIL abort_load_after done=%b count=%0d exp 0/20", done, count); end
        // Reset arriving in a done cycle clears the pulse and the run.
        do_load(2); auto_reload = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        repeat (2) tick();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL abort_done_pre done=%b exp=1", done); end
        reset = 1'b1; tick(); idle_inputs();
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || count !== 8'd0) begin n_bad++; $display("FAIL abort_done_reset done=%b busy=%b count=%0d exp 0/0/0", done, busy, count); end
    endtask

    task automatic test_full_period();
        int done_at = -1;
        int pulses = 0;
        do_reset();
        do_load(255);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (done === 1'b1) begin pulses++; done_at = i; end
        end
        n_cmp++; if (done_at !== 255 || pulses !== 1) begin n_bad++; $display("FAIL full_done at=%0d pulses=%0d exp at=255 pulses=1", done_at, pulses); end
        n_cmp++; if (count !== 8'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL full_end count=%0d busy=%b exp 0/0", count, busy); end
        tick();
        n_cmp++; if (count !== 8'd0 || done !== 1'b0) begin n_bad++; $display("FAIL full_nowrap count=%0d done=%b exp 0/0", count, done); end
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            reset       = ($urandom_range(0, 199) == 0);
            load        = ($urandom_range(0, 29) == 0);
            load_val    = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom_range(0, 255))
                                                      : WIDTH'($urandom_range(0, 6));
            start       = ($urandom_range(0, 3) == 0);
            pause       = ($urandom_range(0, 7) == 0);
            auto_reload = $urandom_range(0, 1) == 1;
            tick();
            n_cmp++;
            if (count !== WIDTH'(m_count) || busy !== (m_mode == 1) || done !== (m_done == 1)) begin
                n_bad++;
                if (errs < 10)
                    $display("FAIL rand_cyc%0d count=%0d busy=%b done=%b exp count=%0d busy=%b done=%b",
                             i, count, busy, done, m_count, (m_mode == 1), (m_done == 1));
                errs++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_auto_reload();
        test_pause();
        test_zero_load();
        test_abort();
        test_full_period();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_down_timer
